// File: rtl/flag_pipeline_unit_if.sv
// Bundle between the flag pipeline and its neighbours: EX capture inputs,
// forwarding-unit handshake, and the flag outputs towards ID/forwarding.
interface flag_pipeline_unit_if #(
  parameter int STAGES = 2
);
  localparam int CNT_W = $clog2(STAGES + 2);

  logic             stall;
  logic             flush;
  logic             ex_valid;
  logic             ex_change_cz;
  logic             ex_carry;
  logic             ex_zero;
  logic             sel_carry_fwd;
  logic             sel_zero_fwd;
  logic             carry_fwd;
  logic             zero_fwd;
  logic             mem_change_cz;
  logic             mem_carry;
  logic             mem_zero;
  logic             arch_carry;
  logic             arch_zero;
  logic             cond_carry;
  logic             cond_zero;
  logic             flags_busy;
  logic [CNT_W-1:0] pending_cnt;

  // Pipeline-control / EX side that drives the unit.
  modport master (
    output stall, flush, ex_valid, ex_change_cz, ex_carry, ex_zero,
    output sel_carry_fwd, sel_zero_fwd, carry_fwd, zero_fwd,
    input  mem_change_cz, mem_carry, mem_zero, arch_carry, arch_zero,
    input  cond_carry, cond_zero, flags_busy, pending_cnt
  );

  // The flag pipeline itself.
  modport slave (
    input  stall, flush, ex_valid, ex_change_cz, ex_carry, ex_zero,
    input  sel_carry_fwd, sel_zero_fwd, carry_fwd, zero_fwd,
    output mem_change_cz, mem_carry, mem_zero, arch_carry, arch_zero,
    output cond_carry, cond_zero, flags_busy, pending_cnt
  );
endinterface

// File: rtl/flag_pipeline_unit.sv
// Carry/zero flag pipeline from EX capture to architectural commit, with
// branch-condition flag resolution (forwarded > youngest in-flight > arch).

// Range checker for the in-flight writer counter.
module flag_pipeline_unit_chk #(
  parameter int STAGES = 2,
  parameter int CNT_W  = 2
) (
  input logic             clk,
  input logic             rst_n,
  input logic [CNT_W-1:0] pending_cnt
);
  a_pending_cnt_range: assert property (
    @(posedge clk) disable iff (!rst_n) (int'(pending_cnt) <= STAGES)
  );
endmodule

module flag_pipeline_unit #(
  parameter int STAGES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  flag_pipeline_unit_if.slave bus
);
  localparam int CNT_W = $clog2(STAGES + 2);

  typedef struct packed {
    logic v;  // slot holds a real instruction
    logic w;  // instruction writes carry/zero
    logic c;  // carry value
    logic z;  // zero value
  } slot_t;

  slot_t            slot_r [1:STAGES];
  logic             arch_carry_r;
  logic             arch_zero_r;
  logic [CNT_W-1:0] cnt_r;

  slot_t            capture_s;
  logic             inc_s;
  logic             dec_s;
  logic             cond_carry_s;
  logic             cond_zero_s;

  // EX capture: a flushed instruction enters slot 1 as a bubble.
  always_comb begin
    capture_s = '0;
    if (bus.flush) begin
      capture_s = '0;
    end else begin
      capture_s.v = bus.ex_valid;
      capture_s.w = bus.ex_valid & bus.ex_change_cz;
      capture_s.c = bus.ex_carry;
      capture_s.z = bus.ex_zero;
    end
  end

  assign inc_s = capture_s.w;
  assign dec_s = slot_r[STAGES].v & slot_r[STAGES].w;

  // Slot shift register; stall freezes every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= STAGES; k++) begin
        slot_r[k] <= '0;
      end
    end else if (!bus.stall) begin
      slot_r[1] <= capture_s;
      for (int k = 2; k <= STAGES; k++) begin
        slot_r[k] <= slot_r[k-1];
      end
    end
  end

  // Architectural flags take the oldest slot when it is a flag writer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arch_carry_r <= 1'b0;
      arch_zero_r  <= 1'b0;
    end else if (!bus.stall && dec_s) begin
      arch_carry_r <= slot_r[STAGES].c;
      arch_zero_r  <= slot_r[STAGES].z;
    end
  end

  // In-flight writer count: +1 on capture, -1 on commit, both cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!bus.stall) begin
      case ({inc_s, dec_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Branch-condition resolution; slot 2 is youngest so it is applied last.
  always_comb begin
    cond_carry_s = arch_carry_r;
    cond_zero_s  = arch_zero_r;
    for (int k = STAGES; k >= 2; k--) begin
      cond_carry_s = (slot_r[k].v & slot_r[k].w) ? slot_r[k].c : cond_carry_s;
      cond_zero_s  = (slot_r[k].v & slot_r[k].w) ? slot_r[k].z : cond_zero_s;
    end
    if (bus.sel_carry_fwd) begin
      cond_carry_s = bus.carry_fwd;
    end else begin
      cond_carry_s = cond_carry_s;
    end
    if (bus.sel_zero_fwd) begin
      cond_zero_s = bus.zero_fwd;
    end else begin
      cond_zero_s = cond_zero_s;
    end
  end

  assign bus.mem_change_cz = slot_r[1].v & slot_r[1].w;
  assign bus.mem_carry     = slot_r[1].c;
  assign bus.mem_zero      = slot_r[1].z;
  assign bus.arch_carry    = arch_carry_r;
  assign bus.arch_zero     = arch_zero_r;
  assign bus.cond_carry    = cond_carry_s;
  assign bus.cond_zero     = cond_zero_s;
  assign bus.pending_cnt   = cnt_r;
  assign bus.flags_busy    = (cnt_r != CNT_W'(0));

  flag_pipeline_unit_chk #(
    .STAGES (STAGES),
    .CNT_W  (CNT_W)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .pending_cnt (cnt_r)
  );
endmodule

// File: tb/tb_flag_pipeline_unit.sv
// Self-checking bench for flag_pipeline_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_flag_pipeline_unit;
  localparam int STAGES = 2;

  typedef struct {
    logic v;
    logic w;
    logic c;
    logic z;
  } mslot_t;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  int     n_checks = 0;
  int     n_errors = 0;

  // Reference state: pipe[0] is slot 1, pipe[STAGES-1] is the oldest slot.
  mslot_t pipe [$];
  logic   m_arch_c;
  logic   m_arch_z;

  // Free-running clock.
  always #5 clk = ~clk;

  flag_pipeline_unit_if #(.STAGES(STAGES)) bus ();

  flag_pipeline_unit #(.STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic mslot_t empty_slot();
    mslot_t s;
    s.v = 1'b0; s.w = 1'b0; s.c = 1'b0; s.z = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < STAGES; i++) pipe.push_back(empty_slot());
    m_arch_c = 1'b0;
    m_arch_z = 1'b0;
  endtask

  // One unstalled edge: oldest entry retires (commits if a writer), new one enters.
  task automatic model_advance();
    mslot_t retire;
    mslot_t fresh;
    if (!bus.stall) begin
      retire = pipe.pop_back();
      if (retire.v && retire.w) begin
        m_arch_c = retire.c;
        m_arch_z = retire.z;
      end
      fresh = empty_slot();
      if (!bus.flush) begin
        fresh.v = bus.ex_valid;
        fresh.w = bus.ex_valid && bus.ex_change_cz;
        fresh.c = bus.ex_carry;
        fresh.z = bus.ex_zero;
      end
      pipe.push_front(fresh);
    end
  endtask

  function automatic int m_pending();
    int n = 0;
    foreach (pipe[i]) if (pipe[i].v && pipe[i].w) n++;
    return n;
  endfunction

  function automatic logic m_cond(input logic is_zero);
    if (!is_zero && bus.sel_carry_fwd) return bus.carry_fwd;
    if (is_zero && bus.sel_zero_fwd) return bus.zero_fwd;
    for (int i = 1; i < STAGES; i++) begin
      if (pipe[i].v && pipe[i].w) return is_zero ? pipe[i].z : pipe[i].c;
    end
    return is_zero ? m_arch_z : m_arch_c;
  endfunction

  task automatic check_all();
    check_eq("mem_change_cz", 8'(bus.mem_change_cz), 8'(pipe[0].v && pipe[0].w));
    check_eq("mem_carry",     8'(bus.mem_carry),     8'(pipe[0].c));
    check_eq("mem_zero",      8'(bus.mem_zero),      8'(pipe[0].z));
    check_eq("arch_carry",    8'(bus.arch_carry),    8'(m_arch_c));
    check_eq("arch_zero",     8'(bus.arch_zero),     8'(m_arch_z));
    check_eq("cond_carry",    8'(bus.cond_carry),    8'(m_cond(1'b0)));
    check_eq("cond_zero",     8'(bus.cond_zero),     8'(m_cond(1'b1)));
    check_eq("pending_cnt",   8'(bus.pending_cnt),   8'(m_pending()));
    check_eq("flags_busy",    8'(bus.flags_busy),    8'(m_pending() != 0));
  endtask

  task automatic drive(input logic st, input logic fl, input logic v,
                       input logic cz, input logic c, input logic z);
    bus.stall        = st;
    bus.flush        = fl;
    bus.ex_valid     = v;
    bus.ex_change_cz = cz;
    bus.ex_carry     = c;
    bus.ex_zero      = z;
  endtask

  task automatic set_fwd(input logic sc, input logic cf, input logic sz, input logic zf);
    bus.sel_carry_fwd = sc;
    bus.carry_fwd     = cf;
    bus.sel_zero_fwd  = sz;
    bus.zero_fwd      = zf;
  endtask

  // Advance one clock, update the model, then compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_advance();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_fwd(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    check_all();
    check_eq("rst_pending", 8'(bus.pending_cnt), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single writer: visible in slot 1 after one edge, committed after two.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle();
    check_eq("sw_mem_cz",    8'(bus.mem_change_cz), 8'd1);
    check_eq("sw_mem_carry", 8'(bus.mem_carry),     8'd1);
    check_eq("sw_cnt_e0",    8'(bus.pending_cnt),   8'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check_eq("sw_arch_e1",   8'(bus.arch_carry),    8'd0);
    check_eq("sw_cnt_e1",    8'(bus.pending_cnt),   8'd1);
    cycle();
    check_eq("sw_arch_e2",   8'(bus.arch_carry),    8'd1);
    check_eq("sw_cnt_e2",    8'(bus.pending_cnt),   8'd0);

    // Flushed writer never reaches slot 1 or the architectural flags.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle();
    check_eq("fl_mem_cz", 8'(bus.mem_change_cz), 8'd0);
    check_eq("fl_cnt",    8'(bus.pending_cnt),   8'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    check_eq("fl_arch_c", 8'(bus.arch_carry), 8'd1);
    check_eq("fl_arch_z", 8'(bus.arch_zero),  8'd0);

    // Stall hold with a writer in slot 2; flush during stall is ignored.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      else        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      check_eq("st_arch_c", 8'(bus.arch_carry),  8'd1);
      check_eq("st_cnt",    8'(bus.pending_cnt), 8'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check_eq("st_commit_c", 8'(bus.arch_carry),  8'd0);
    check_eq("st_commit_z", 8'(bus.arch_zero),   8'd1);
    check_eq("st_cnt_done", 8'(bus.pending_cnt), 8'd0);

    // Back-to-back writers, then a non-writer.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    check_eq("bb_peak", 8'(bus.pending_cnt), 8'd2);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle();
    check_eq("bb_incdec", 8'(bus.pending_cnt), 8'd2);
    check_eq("bb_mid_c",  8'(bus.arch_carry),  8'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    check_eq("bb_final_c", 8'(bus.arch_carry),  8'd0);
    check_eq("bb_final_z", 8'(bus.arch_zero),   8'd1);
    check_eq("bb_drained", 8'(bus.pending_cnt), 8'd0);

    // Resolution priority: forward > slot 2 writer > architectural.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    set_fwd(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("rp_fwd",      8'(bus.cond_carry), 8'd0);
    check_all();
    set_fwd(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("rp_slot2_c",  8'(bus.cond_carry), 8'd1);
    check_eq("rp_slot2_z",  8'(bus.cond_zero),  8'd0);
    cycle();
    check_eq("rp_arch_c",   8'(bus.cond_carry), 8'd1);
    set_fwd(1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    check_eq("rp_fwd_z",    8'(bus.cond_zero),  8'd1);
    set_fwd(1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset with two writers in flight.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    check_eq("mr_full", 8'(bus.pending_cnt), 8'd2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("mr_cnt",    8'(bus.pending_cnt),   8'd0);
    check_eq("mr_arch_c", 8'(bus.arch_carry),    8'd0);
    check_eq("mr_mem_cz", 8'(bus.mem_change_cz), 8'd0);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("mr_arch_hold", 8'(bus.arch_carry), 8'd0);
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom));
      set_fwd(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      check_all();
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/flag_pipeline_unit.md
Name: flag_pipeline_unit

Overview:
Holds the carry/zero flag pipeline between the EX stage and architectural commit. Captures ALU flag results with their write-enable, carries them through STAGES pipeline slots, and commits them into the architectural carry/zero register at the last slot. Drives the first slot's contents into the carry/zero forwarding unit downstream. Muxes that unit's forwarding result against older in-flight flags and the architectural flags to produce the branch-condition flags consumed in ID.

Parameters:
STAGES, 2, number of flag pipeline slots between EX capture and commit (MEM..WB); legal range 2..4
CNT_W, $clog2(STAGES+2), width of the in-flight writer counter (derived, not overridden)

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  freeze: no slot advances, no commit, counter holds
flush  input  1  kill the EX-stage capture this cycle (older slots unaffected)
ex_valid  input  1  EX stage holds a real instruction
ex_change_cz  input  1  EX instruction writes carry/zero
ex_carry  input  1  ALU carry result
ex_zero  input  1  ALU zero result
sel_carry_fwd  input  1  from forwarding unit: use carry_fwd
sel_zero_fwd  input  1  from forwarding unit: use zero_fwd
carry_fwd  input  1  forwarded carry value
zero_fwd  input  1  forwarded zero value
mem_change_cz  output  1  slot 1 valid and flag-writing (to forwarding unit)
mem_carry  output  1  slot 1 carry
mem_zero  output  1  slot 1 zero
arch_carry  output  1  committed carry
arch_zero  output  1  committed zero
cond_carry  output  1  resolved carry for branch evaluation
cond_zero  output  1  resolved zero for branch evaluation
flags_busy  output  1  at least one flag writer in flight
pending_cnt  output  CNT_W  number of flag writers in slots 1..STAGES

Behaviour:
- Slot k (1..STAGES) holds {v, w, c, z}; w = write-enable, only meaningful when v=1.
- Reset (rst_n low, async): every slot = 0, arch_carry = arch_zero = 0, pending_cnt = 0. All outputs therefore 0 immediately, including mid-operation. In-flight writers are discarded.
- Advance, on each posedge with stall=0:
  - slot1 <= flush ? 0 : {ex_valid, ex_valid & ex_change_cz, ex_carry, ex_zero}
  - slot k <= slot k-1 for k=2..STAGES
- Commit, same posedge with stall=0: if slotSTAGES.v & w, then arch_carry <= slotSTAGES.c and arch_zero <= slotSTAGES.z. Otherwise arch flags hold.
- stall=1: all state holds. stall overrides flush; a flush asserted during stall has no effect.
- Counter, updated only when stall=0:
  - inc = captured w bit (0 if flush); dec = slotSTAGES.v & w
  - pending_cnt += inc - dec; simultaneous inc and dec leaves it unchanged
  - Never wraps; max value STAGES. Any value outside 0..STAGES is an assertion failure.
  - flags_busy = (pending_cnt != 0), combinational from the register.
- mem_change_cz = slot1.v & slot1.w; mem_carry = slot1.c; mem_zero = slot1.z. All registered; latency 1 cycle from EX capture.
- Resolution is combinational; carry and zero resolve independently:
  - cond_carry = sel_carry_fwd ? carry_fwd : youngest slot k in 2..STAGES with v&w ? that slot's c : arch_carry.
  - cond_zero resolves identically using sel_zero_fwd, zero_fwd, slot z, arch_zero.
  - Slot 2 is youngest; slot 1 is covered only by the forwarding unit.
- Commit-to-architectural latency = STAGES cycles after capture, excluding stalled cycles.

Test Plan:
- Reset mid-stream: pending_cnt=2, slots full; drop rst_n asynchronously -> all outputs 0 before next edge; after release, arch flags stay 0 until a new writer commits.
- Single writer, STAGES=2: ex_valid=1, ex_change_cz=1, c=1, z=0 at edge 0 -> mem_change_cz=1, mem_carry=1 after edge 0; arch_carry=1 after edge 2; pending_cnt 1,1,0.
- Flush: writer presented with flush=1 -> slot1=0, mem_change_cz=0, pending_cnt unchanged, arch flags never change.
- Stall hold: writer in slot 2, stall=1 for 3 cycles -> arch_carry unchanged and pending_cnt constant; commit occurs on the first non-stalled edge.
- Back-to-back writers (c=1,z=1 then c=0,z=1) plus a non-writer -> pending_cnt peaks at 2 and holds on simultaneous inc/dec; final arch_carry=0, arch_zero=1.
- Resolution priority: sel_carry_fwd=1, carry_fwd=0, slot2 writer c=1, arch_carry=1 -> cond_carry=0. Drop sel -> cond_carry=1. Slot2 invalid -> cond_carry=arch_carry.
